// File: rtl/sequenciador_regras.sv
// Rule sequencer on the initiator side of the inference interface: sweeps the 9 antecedent
// codes, captures each rule's interval firing once the unit settles, and max-aggregates it.
module sequenciador_regras #(
   parameter int LAT_INF = 2,
   parameter int N_SETS  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iniciar,
   input  logic [7:0] saida_UP_0,
   input  logic [7:0] saida_UP_1,
   input  logic [7:0] saida_UP_2,
   input  logic [7:0] saida_LOW_0,
   input  logic [7:0] saida_LOW_1,
   input  logic [7:0] saida_LOW_2,
   output logic [3:0] Sequencia_regras,
   output logic       EN_Cod_Mem,
   output logic [7:0] agg_UP_0,
   output logic [7:0] agg_UP_1,
   output logic [7:0] agg_UP_2,
   output logic [7:0] agg_LOW_0,
   output logic [7:0] agg_LOW_1,
   output logic [7:0] agg_LOW_2,
   output logic       saida_valida,
   input  logic       pronto_in,
   output logic       ocupado,
   output logic       erro_fou
);

   localparam logic [3:0] LAST_IDX = 4'(N_SETS * N_SETS - 1);
   localparam logic [3:0] WAIT_END = 4'(LAT_INF - 1);

   typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CAPTURE, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [3:0]       wcnt_q, wcnt_d;
   logic [2:0][7:0]  up_q, up_d, low_q, low_d;
   logic             erro_q, erro_d;
   logic [2:0][7:0]  in_up, in_low;
   logic [3:0]       rule_code;

   assign in_up  = {saida_UP_2, saida_UP_1, saida_UP_0};
   assign in_low = {saida_LOW_2, saida_LOW_1, saida_LOW_0};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         wcnt_q  <= '0;
         up_q    <= '0;
         low_q   <= '0;
         erro_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wcnt_q  <= wcnt_d;
         up_q    <= up_d;
         low_q   <= low_d;
         erro_q  <= erro_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (iniciar) state_d = S_DRIVE;
         S_DRIVE:   state_d = S_WAIT;
         S_WAIT:    if (wcnt_q == WAIT_END) state_d = S_CAPTURE;
         S_CAPTURE: state_d = (idx_q == LAST_IDX) ? S_DONE : S_DRIVE;
         S_DONE:    if (pronto_in) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Aggregates only move on the start edge (clear) and in CAPTURE (max-merge).
   always_comb begin
      idx_d  = idx_q;
      wcnt_d = wcnt_q;
      up_d   = up_q;
      low_d  = low_q;
      erro_d = erro_q;
      case (state_q)
         S_IDLE: begin
            if (iniciar) begin
               idx_d  = '0;
               up_d   = '0;
               low_d  = '0;
               erro_d = 1'b0;
            end
         end
         S_DRIVE: wcnt_d = '0;
         S_WAIT:  wcnt_d = wcnt_q + 4'd1;
         S_CAPTURE: begin
            for (int k = 0; k < 3; k++) begin
               if (in_up[k] > up_q[k])   up_d[k]  = in_up[k];
               if (in_low[k] > low_q[k]) low_d[k] = in_low[k];
               if (in_low[k] > in_up[k]) erro_d   = 1'b1;
            end
            if (idx_q != LAST_IDX) idx_d = idx_q + 4'd1;
         end
         default: ;
      endcase
   end

   // Rule index to code: [3:2] input-2 set, [1:0] input-1 set.
   assign rule_code = {2'(idx_q / 4'(N_SETS)), 2'(idx_q % 4'(N_SETS))};

   always_comb begin
      Sequencia_regras = 4'd0;
      EN_Cod_Mem       = 1'b0;
      saida_valida     = 1'b0;
      ocupado          = (state_q != S_IDLE);
      case (state_q)
         S_DRIVE: begin
            Sequencia_regras = rule_code;
            EN_Cod_Mem       = 1'b1;
         end
         S_WAIT, S_CAPTURE: Sequencia_regras = rule_code;
         S_DONE:            saida_valida     = 1'b1;
         default: ;
      endcase
   end

   assign agg_UP_0  = up_q[0];
   assign agg_UP_1  = up_q[1];
   assign agg_UP_2  = up_q[2];
   assign agg_LOW_0 = low_q[0];
   assign agg_LOW_1 = low_q[1];
   assign agg_LOW_2 = low_q[2];
   assign erro_fou  = erro_q;

endmodule

// File: tb/tb_sequenciador_regras.sv
// Bench for sequenciador_regras: stub inference unit with random tables, a cycle-level
// behavioural model checked every cycle, plus literal expectations for the directed cases.
module tb_sequenciador_regras;
   localparam int LAT = 2;
   localparam int RULE_CYC = LAT + 2;
   localparam int SWEEP = 9 * RULE_CYC + 1;

   logic clk = 1'b0;
   logic rst, iniciar, pronto_in;
   logic [7:0] s_up[3], s_low[3];
   logic [3:0] Sequencia_regras;
   logic EN_Cod_Mem, saida_valida, ocupado, erro_fou;
   logic [7:0] a_up[3], a_low[3];

   sequenciador_regras #(.LAT_INF(LAT), .N_SETS(3)) dut (
      .clk(clk), .rst(rst), .iniciar(iniciar),
      .saida_UP_0(s_up[0]), .saida_UP_1(s_up[1]), .saida_UP_2(s_up[2]),
      .saida_LOW_0(s_low[0]), .saida_LOW_1(s_low[1]), .saida_LOW_2(s_low[2]),
      .Sequencia_regras(Sequencia_regras), .EN_Cod_Mem(EN_Cod_Mem),
      .agg_UP_0(a_up[0]), .agg_UP_1(a_up[1]), .agg_UP_2(a_up[2]),
      .agg_LOW_0(a_low[0]), .agg_LOW_1(a_low[1]), .agg_LOW_2(a_low[2]),
      .saida_valida(saida_valida), .pronto_in(pronto_in),
      .ocupado(ocupado), .erro_fou(erro_fou)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_fail = 0;
   int cyc = 0;
   int up_tab[16][3], low_tab[16][3];
   int codes_seen[$], en_cycles[$];
   bit valid_seen;
   int valid_cyc, t0;
   bit pend = 0;
   int cnt = 0, lcode = 0;
   int exp_codes[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int code_of(input int idx);
      return (idx / 3) * 4 + idx % 3;
   endfunction

   // One clock: observe outputs mid-cycle, then act as the inference unit for the next cycle.
   task automatic tick();
      bit en_s;
      int code_s;
      @(negedge clk);
      en_s = EN_Cod_Mem;
      code_s = int'(Sequencia_regras);
      if (en_s) begin
         codes_seen.push_back(code_s);
         en_cycles.push_back(cyc);
      end
      if (saida_valida && !valid_seen) begin
         valid_seen = 1;
         valid_cyc = cyc;
      end
      @(posedge clk);
      cyc++;
      if (en_s) begin pend = 1; cnt = 1; lcode = code_s; end
      else if (pend) cnt++;
      #1;
      for (int k = 0; k < 3; k++) begin
         if (pend && cnt == LAT + 1) begin
            s_up[k]  = 8'(up_tab[lcode][k]);
            s_low[k] = 8'(low_tab[lcode][k]);
         end else begin
            s_up[k]  = 8'($urandom_range(128, 255));
            s_low[k] = 8'($urandom_range(128, 255));
         end
      end
   endtask

   task automatic fill_det();
      for (int i = 0; i < 9; i++)
         for (int k = 0; k < 3; k++) begin
            up_tab[code_of(i)][k]  = 10 * (i + 1) + k;
            low_tab[code_of(i)][k] = 10 * (i + 1) + k - 5;
         end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 9; i++)
         for (int k = 0; k < 3; k++) begin
            up_tab[code_of(i)][k]  = $urandom_range(0, 127);
            low_tab[code_of(i)][k] = $urandom_range(0, up_tab[code_of(i)][k]);
         end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!valid_seen && n < 200) begin
         tick();
         n++;
      end
      if (!valid_seen) chk("valid_timeout", 0, 1);
   endtask

   task automatic start_and_wait(input bit noise);
      int mu, ml, me;
      codes_seen.delete();
      en_cycles.delete();
      valid_seen = 0;
      iniciar = 1;
      t0 = cyc;
      tick();
      iniciar = 0;
      chk("start_clears_err", int'(erro_fou), 0);
      chk("start_clears_up0", int'(a_up[0]), 0);
      chk("start_busy", int'(ocupado), 1);
      while (!valid_seen && cyc - t0 < 200) begin
         if (noise) iniciar = 1'($urandom_range(0, 1));
         tick();
      end
      iniciar = 0;
      if (!valid_seen) chk("valid_timeout", 0, 1);
      chk("valid_latency", valid_cyc - t0, 37);
      chk("en_count", codes_seen.size(), 9);
      for (int i = 0; i < 9 && i < codes_seen.size(); i++) begin
         chk("rule_code", codes_seen[i], exp_codes[i]);
         chk("en_cycle", en_cycles[i] - t0, 1 + RULE_CYC * i);
      end
      me = 0;
      for (int k = 0; k < 3; k++) begin
         mu = 0; ml = 0;
         for (int i = 0; i < 9; i++) begin
            if (up_tab[code_of(i)][k] > mu)  mu = up_tab[code_of(i)][k];
            if (low_tab[code_of(i)][k] > ml) ml = low_tab[code_of(i)][k];
            if (low_tab[code_of(i)][k] > up_tab[code_of(i)][k]) me = 1;
         end
         chk("table_max_up", int'(a_up[k]), mu);
         chk("table_max_low", int'(a_low[k]), ml);
      end
      chk("table_err", int'(erro_fou), me);
   endtask

   task automatic finish_xfer(input int stall, input bit noise, input bit btb);
      int su[3], sl[3], se;
      for (int k = 0; k < 3; k++) begin su[k] = a_up[k]; sl[k] = a_low[k]; end
      se = erro_fou;
      repeat (stall) begin
         if (noise) iniciar = 1'($urandom_range(0, 1));
         tick();
      end
      iniciar = btb;
      chk("stall_valid", int'(saida_valida), 1);
      for (int k = 0; k < 3; k++) begin
         chk("stall_up", int'(a_up[k]), su[k]);
         chk("stall_low", int'(a_low[k]), sl[k]);
      end
      chk("stall_err", int'(erro_fou), se);
      pronto_in = 1;
      tick();
      pronto_in = 0;
      chk("xfer_idle", int'(ocupado), 0);
      chk("keep_up0", int'(a_up[0]), su[0]);
      if (btb) begin
         tick();
         chk("btb_start", int'(ocupado), 1);
      end
      iniciar = 0;
   endtask

   // Behavioural model: position in the sweep is derived from cycles elapsed since start.
   initial begin : model
      bit m_ok = 0, m_busy = 0, m_done = 0;
      int m_rel = 0, m_up[3], m_low[3], m_err = 0;
      int ph, rule, e_code;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_ok = 1; m_busy = 0; m_done = 0; m_err = 0;
            for (int k = 0; k < 3; k++) begin m_up[k] = 0; m_low[k] = 0; end
         end else if (m_ok) begin
            if (m_busy) begin
               if ((m_rel - 1) % RULE_CYC == RULE_CYC - 1)
                  for (int k = 0; k < 3; k++) begin
                     if (int'(s_up[k]) > m_up[k])   m_up[k]  = s_up[k];
                     if (int'(s_low[k]) > m_low[k]) m_low[k] = s_low[k];
                     if (s_low[k] > s_up[k]) m_err = 1;
                  end
               m_rel++;
               if (m_rel == SWEEP) begin m_busy = 0; m_done = 1; end
            end else if (m_done) begin
               if (pronto_in) m_done = 0;
            end else if (iniciar) begin
               m_busy = 1; m_rel = 1; m_err = 0;
               for (int k = 0; k < 3; k++) begin m_up[k] = 0; m_low[k] = 0; end
            end
         end
         @(negedge clk);
         if (m_ok) begin
            ph = (m_rel - 1) % RULE_CYC;
            rule = (m_rel - 1) / RULE_CYC;
            e_code = m_busy ? code_of(rule) : 0;
            chk("m_ocupado", int'(ocupado), int'(m_busy || m_done));
            chk("m_en", int'(EN_Cod_Mem), int'(m_busy && ph == 0));
            chk("m_code", int'(Sequencia_regras), e_code);
            chk("m_valid", int'(saida_valida), int'(m_done));
            chk("m_err", int'(erro_fou), m_err);
            for (int k = 0; k < 3; k++) begin
               chk("m_agg_up", int'(a_up[k]), m_up[k]);
               chk("m_agg_low", int'(a_low[k]), m_low[k]);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      rst = 1; iniciar = 0; pronto_in = 0;
      for (int k = 0; k < 3; k++) begin s_up[k] = 0; s_low[k] = 0; end
      repeat (2) tick();
      rst = 0;
      repeat (8) tick();
      chk("idle_busy", int'(ocupado), 0);
      chk("idle_code", int'(Sequencia_regras), 0);
      chk("idle_valid", int'(saida_valida), 0);
      chk("idle_agg_low2", int'(a_low[2]), 0);

      // Directed aggregation: UP_k = 10*(idx+1)+k, LOW_k = UP_k-5
      fill_det();
      start_and_wait(0);
      chk("det_up0", int'(a_up[0]), 90);
      chk("det_up1", int'(a_up[1]), 91);
      chk("det_up2", int'(a_up[2]), 92);
      chk("det_low0", int'(a_low[0]), 85);
      chk("det_low1", int'(a_low[1]), 86);
      chk("det_low2", int'(a_low[2]), 87);
      chk("det_err", int'(erro_fou), 0);
      finish_xfer(0, 0, 0);

      // Footprint-of-uncertainty error on rule 4 (code 5), with a 20-cycle stall
      fill_rand();
      up_tab[5][1] = 100;
      low_tab[5][1] = 200;
      start_and_wait(1);
      chk("fou_err", int'(erro_fou), 1);
      chk("fou_low1", int'(a_low[1]), 200);
      finish_xfer(20, 1, 0);
      fill_rand();
      start_and_wait(0);
      finish_xfer(3, 1, 1);
      valid_seen = 0;
      wait_valid();
      finish_xfer(1, 0, 0);

      // Reset during WAIT of rule 5, then a clean sweep
      fill_det();
      iniciar = 1;
      tick();
      iniciar = 0;
      repeat (5 * RULE_CYC + 1) tick();
      rst = 1;
      tick();
      rst = 0;
      chk("rst_busy", int'(ocupado), 0);
      chk("rst_up2", int'(a_up[2]), 0);
      chk("rst_err", int'(erro_fou), 0);
      repeat (2) tick();
      fill_rand();
      start_and_wait(0);
      finish_xfer(0, 0, 0);

      for (int r = 0; r < 4; r++) begin
         fill_rand();
         if (r == 2) low_tab[code_of($urandom_range(0, 8))][$urandom_range(0, 2)] = 255;
         repeat ($urandom_range(0, 3)) tick();
         start_and_wait(1);
         finish_xfer($urandom_range(0, 6), 1, 0);
      end
      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sequenciador_regras.md
Name: sequenciador_regras

Overview:
- Initiator side of the inference interface.
- On a start pulse it steps the 4-bit rule code through the 9 valid antecedent combinations: 3 sets per input, codes {0,1,2,4,5,6,8,9,10}.
- For each rule it pulses EN_Cod_Mem, waits for the inference unit to settle, then captures the upper/lower firing values of the 3 output sets.
- It max-aggregates those values across all rules and presents the aggregated interval firing strengths to the type-reduction stage with a valid/ready handshake.

Parameters:
- LAT_INF, 2, cycles between the EN_Cod_Mem pulse and valid inference outputs (legal range 1..15).
- N_SETS, 3, fuzzy sets per antecedent (fixed at 3; the 2-bit fields take values 0..2).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- iniciar  in  1  start request, sampled only in IDLE
- saida_UP_0, saida_UP_1, saida_UP_2  in  8 each  upper firing of the current rule, per output set
- saida_LOW_0, saida_LOW_1, saida_LOW_2  in  8 each  lower firing of the current rule, per output set
- Sequencia_regras  out  4  rule code to the inference unit; [1:0] = input-1 set, [3:2] = input-2 set
- EN_Cod_Mem  out  1  one-cycle enable per rule
- agg_UP_0, agg_UP_1, agg_UP_2  out  8 each  max of upper firing over all rules
- agg_LOW_0, agg_LOW_1, agg_LOW_2  out  8 each  max of lower firing over all rules
- saida_valida  out  1  aggregated results valid
- pronto_in  in  1  downstream ready
- ocupado  out  1  high in every state except IDLE
- erro_fou  out  1  sticky flag: some captured LOW exceeded its UP

Behaviour:
- Reset: on rst=1 at a clock edge, all outputs go to 0 and the FSM goes to IDLE. This applies in any state, including mid-sweep and in DONE; partial aggregates are discarded.
- States: IDLE, DRIVE, WAIT, CAPTURE, DONE.
- IDLE:
  - Sequencia_regras=0, EN_Cod_Mem=0.
  - iniciar=1 moves the FSM to DRIVE with rule index 0 on the next cycle.
  - The same edge clears agg_* and erro_fou to 0.
- DRIVE:
  - Sequencia_regras = {idx/3, idx%3} packed as [3:2],[1:0]; EN_Cod_Mem=1 for exactly this cycle.
  - Next state is WAIT and the wait counter loads 0.
- WAIT:
  - Sequencia_regras is held and EN_Cod_Mem=0.
  - Stay for exactly LAT_INF cycles, then go to CAPTURE.
- CAPTURE:
  - Sequencia_regras is held.
  - For each k in 0..2: agg_UP_k <= max(agg_UP_k, saida_UP_k); agg_LOW_k <= max(agg_LOW_k, saida_LOW_k). Comparisons are unsigned 8-bit; no overflow is possible.
  - If any saida_LOW_k > saida_UP_k this cycle, erro_fou <= 1. It stays set until the next start.
  - If idx=8, go to DONE. Otherwise increment idx and go to DRIVE.
- Per-rule cost is LAT_INF+2 cycles.
- If iniciar is sampled in cycle t, saida_valida rises in cycle t+9*(LAT_INF+2)+1. With the default this is t+37.
- DONE:
  - saida_valida=1; agg_* and erro_fou are stable.
  - Sequencia_regras returns to 0.
  - When saida_valida & pronto_in are both high, the transfer completes and the FSM goes to IDLE next cycle.
- Handshake:
  - saida_valida must not drop before a transfer.
  - Back-to-back: if iniciar is high in the transfer cycle it is ignored. It is sampled from the first IDLE cycle onward.
- iniciar while ocupado=1 is ignored, with no queuing.
- The codes 3, 7, 11, 12-15 are never driven.
- agg_* keep their last values after the transfer until the next start clears them.

Test Plan:
- Reset then idle: rst for 2 cycles, iniciar=0 → all outputs 0, ocupado=0, Sequencia_regras=0 indefinitely.
- Code sweep, LAT_INF=2, iniciar pulse at cycle 10:
  - EN_Cod_Mem pulses at cycles 11,15,19,...,43.
  - Sequencia_regras sequence is 0,1,2,4,5,6,8,9,10.
  - saida_valida rises at cycle 47.
- Aggregation, model returning UP_k=10*(idx+1)+k and LOW_k=UP_k-5:
  - Result agg_UP = 90,91,92; agg_LOW = 85,86,87; erro_fou=0.
  - A model that changes its outputs during WAIT must not affect the result.
- FOU error: rule 4 returns LOW_1=200, UP_1=100 → erro_fou=1 at DONE, agg_LOW_1=200; the next start clears erro_fou to 0.
- Handshake stall: pronto_in=0 for 20 cycles after saida_valida → outputs stable and iniciar ignored; pronto_in=1 → IDLE next cycle, and a new iniciar starts the sweep.
- Reset mid-sweep: rst asserted during WAIT of rule 5 → next cycle is IDLE with all outputs 0; a new sweep yields correct aggregates with no stale maxima.
